// File: rtl/inst_mem_loader.sv
// Instruction memory for the core: combinational fetch port plus a byte-stream
// program loader that fills the word array while holding the core in reset.
module inst_mem_loader #(
  parameter int unsigned AW  = 12,
  parameter logic [31:0] NOP = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   inst_addr_i,
  output logic [31:0]   inst_o,
  output logic          core_rst_o,
  input  logic          ld_start_i,
  input  logic          ld_valid_i,
  input  logic [7:0]    ld_byte_i,
  input  logic          ld_last_i,
  output logic          ld_ready_o,
  output logic          ld_done_o,
  output logic [AW:0]   ld_words_o,
  output logic          err_o
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned PW    = AW + 1;

  typedef enum logic [1:0] {RUN, LOAD, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [AW:0] ptr_q, ptr_d;
  logic [23:0] asm_q, asm_d;
  logic        core_rst_q, core_rst_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        in_range_c, misaligned_c, fetch_ok_c, accept_c, we_c;
  logic [31:0] wdata_c;

  logic [31:0] mem [DEPTH];

  // Fetch path: only aligned, in-range addresses while the core is running
  assign in_range_c   = (inst_addr_i[31:AW+2] == '0);
  assign misaligned_c = |inst_addr_i[1:0];
  assign fetch_ok_c   = (state_q == RUN) && in_range_c && !misaligned_c;
  assign inst_o       = fetch_ok_c ? mem[inst_addr_i[AW+1:2]] : NOP;

  // A restart in the same cycle wins over an offered byte
  assign accept_c = (state_q == LOAD) && ready_q && ld_valid_i && !ld_start_i;

  // Word being written: stored lower lanes, new byte, zeros above
  always_comb begin
    wdata_c = '0;
    case (lane_q)
      2'd0:    wdata_c = {24'h0, ld_byte_i};
      2'd1:    wdata_c = {16'h0, ld_byte_i, asm_q[7:0]};
      2'd2:    wdata_c = {8'h0, ld_byte_i, asm_q[15:0]};
      default: wdata_c = {ld_byte_i, asm_q[23:0]};
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    ptr_d   = ptr_q;
    asm_d   = asm_q;
    err_d   = err_q;
    we_c    = 1'b0;
    case (state_q)
      RUN: begin
        err_d = err_q | misaligned_c;
        if (ld_start_i) begin
          state_d = LOAD;
          lane_d  = '0;
          ptr_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (ld_start_i) begin
          lane_d = '0;
          ptr_d  = '0;
          err_d  = 1'b0;
        end else if (accept_c) begin
          asm_d  = wdata_c[23:0];
          lane_d = lane_q + 2'd1;
          if ((lane_q == 2'd3) || ld_last_i) begin
            if (ptr_q[AW]) begin
              err_d = 1'b1;
            end else begin
              we_c  = 1'b1;
              ptr_d = ptr_q + PW'(1);
            end
          end
          if (ld_last_i) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    core_rst_d = (state_d != RUN);
    ready_d    = (state_d == LOAD);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      lane_q     <= '0;
      ptr_q      <= '0;
      asm_q      <= '0;
      core_rst_q <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      ptr_q      <= ptr_d;
      asm_q      <= asm_d;
      core_rst_q <= core_rst_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Array contents survive reset
  always_ff @(posedge clk) begin
    if (we_c && !rst) begin
      mem[ptr_q[AW-1:0]] <= wdata_c;
    end
  end

  assign core_rst_o = core_rst_q;
  assign ld_ready_o = ready_q;
  assign ld_done_o  = done_q;
  assign ld_words_o = ptr_q;
  assign err_o      = err_q;

endmodule
